// File: rtl/fp_sweep_cmp_pkg.sv
// Shared types and constants for the floating-point operand sweeper/comparator.
// NRAS/NTYPES/NEXCEPTIONS carry the same values as the shared IEEE-754 flags header.
package fp_sweep_cmp_pkg;

    localparam int unsigned NRAS        = 5;
    localparam int unsigned NTYPES      = 10;
    localparam int unsigned NEXCEPTIONS = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        HALT  = 3'd4
    } state_e;

    // Magnitude bits (exponent+significand) of the largest finite value.
    function automatic logic [63:0] maxf(input int unsigned nexp, input int unsigned nsig);
        logic [63:0] e;
        logic [63:0] s;
        e = (64'd1 << nexp) - 64'd2;
        s = (64'd1 << nsig) - 64'd1;
        return (e << nsig) | s;
    endfunction

endpackage

// File: rtl/fp_operand_step.sv
// Next finite operand in the order +0..+MAXF, -0..-MAXF; wrap_c_o flags -MAXF -> +0.
module fp_operand_step
    import fp_sweep_cmp_pkg::*;
#(
    parameter  int unsigned NEXP = 5,
    parameter  int unsigned NSIG = 10,
    localparam int unsigned W    = NEXP + NSIG + 1
) (
    input  logic [W-1:0] op_i,
    output logic [W-1:0] next_c_o,
    output logic         wrap_c_o
);

    localparam logic [W-2:0] MAXF_MAG = (W-1)'(maxf(NEXP, NSIG));

    logic at_max_c;

    // Incrementing the magnitude walks exponent and significand together;
    // the jump at MAXF skips every exp=all-ones encoding.
    assign at_max_c = (op_i[W-2:0] == MAXF_MAG);
    assign next_c_o = at_max_c ? {~op_i[W-1], (W-1)'(0)} : op_i + W'(1);
    assign wrap_c_o = at_max_c & op_i[W-1];

endmodule

// File: rtl/fp_sweep_cmp.sv
// Exhaustive operand/rounding-attribute sweeper with bit-exact DUT/reference compare.
// Optional flag/exception comparison is enabled with FP_SWEEP_FLAGS_CMP_EN.
module fp_sweep_cmp
    import fp_sweep_cmp_pkg::*;
#(
    parameter  int unsigned NEXP = 5,
    parameter  int unsigned NSIG = 10,
    parameter  int unsigned LAT  = 0,
    parameter  int unsigned CW   = 32,
    localparam int unsigned W    = NEXP + NSIG + 1
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic                   stop_on_err,
    input  logic                   sweep_ra,
    input  logic [NRAS-1:0]        ra_fixed,
    output logic [W-1:0]           a,
    output logic [W-1:0]           b,
    output logic [NRAS-1:0]        ra,
    input  logic [W-1:0]           s_dut,
    input  logic [W-1:0]           s_ref,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [CW-1:0]          err_count,
    output logic [W-1:0]           err_a,
    output logic [W-1:0]           err_b,
    output logic [NRAS-1:0]        err_ra,
    output logic [W-1:0]           err_dut,
    output logic [W-1:0]           err_ref
`ifdef FP_SWEEP_FLAGS_CMP_EN
    ,
    input  logic [NTYPES-1:0]      flags_dut,
    input  logic [NTYPES-1:0]      flags_ref,
    input  logic [NEXCEPTIONS-1:0] exc_dut,
    input  logic [NEXCEPTIONS-1:0] exc_ref,
    output logic [NTYPES-1:0]      err_flags_dut,
    output logic [NTYPES-1:0]      err_flags_ref,
    output logic [NEXCEPTIONS-1:0] err_exc_dut,
    output logic [NEXCEPTIONS-1:0] err_exc_ref
`endif
);

    typedef struct packed {
        logic            valid;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [NRAS-1:0] ra;
    } entry_t;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [NRAS-1:0] ra_q, ra_d;
    logic            stop_q, stop_d, sweep_q, sweep_d;
    logic            busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    err_a_q, err_a_d, err_b_q, err_b_d;
    logic [NRAS-1:0] err_ra_q, err_ra_d;
    logic [W-1:0]    err_dut_q, err_dut_d, err_ref_q, err_ref_d;
`ifdef FP_SWEEP_FLAGS_CMP_EN
    logic [NTYPES-1:0]      eflags_dut_q, eflags_dut_d, eflags_ref_q, eflags_ref_d;
    logic [NEXCEPTIONS-1:0] eexc_dut_q, eexc_dut_d, eexc_ref_q, eexc_ref_d;
`endif

    logic [W-1:0] a_nxt_c, b_nxt_c;
    logic         a_wrap_c, b_wrap_c, last_c, active_c, flush_c, inflight_c, diff_c, mismatch_c;
    entry_t       push_c, cmp_c;

    fp_operand_step #(.NEXP(NEXP), .NSIG(NSIG)) u_step_a (
        .op_i     (a_q),
        .next_c_o (a_nxt_c),
        .wrap_c_o (a_wrap_c)
    );

    fp_operand_step #(.NEXP(NEXP), .NSIG(NSIG)) u_step_b (
        .op_i     (b_q),
        .next_c_o (b_nxt_c),
        .wrap_c_o (b_wrap_c)
    );

    assign active_c = (state_q == RUN) || (state_q == DRAIN);
    assign flush_c  = !active_c;
    assign push_c   = '{valid: (state_q == RUN), a: a_q, b: b_q, ra: ra_q};
    assign last_c   = a_wrap_c && b_wrap_c && (!sweep_q || ra_q[NRAS-1]);

    // Delay line aligning issued operands with results arriving LAT cycles later.
    generate
        if (LAT == 0) begin : g_comb
            assign cmp_c      = push_c;
            assign inflight_c = 1'b0;
        end else begin : g_dl
            entry_t dl_q [LAT];

            always_ff @(posedge clk) begin
                if (clr || flush_c) begin
                    for (int i = 0; i < int'(LAT); i++) dl_q[i] <= '0;
                end else begin
                    dl_q[0] <= push_c;
                    for (int i = 1; i < int'(LAT); i++) dl_q[i] <= dl_q[i-1];
                end
            end

            always_comb begin
                inflight_c = 1'b0;
                for (int i = 0; i < int'(LAT); i++) inflight_c = inflight_c | dl_q[i].valid;
            end

            assign cmp_c = dl_q[LAT-1];
        end
    endgenerate

`ifdef FP_SWEEP_FLAGS_CMP_EN
    assign diff_c = (s_dut != s_ref) || (flags_dut != flags_ref) || (exc_dut != exc_ref);
`else
    assign diff_c = (s_dut != s_ref);
`endif
    assign mismatch_c = active_c && cmp_c.valid && diff_c;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        ra_d      = ra_q;
        stop_d    = stop_q;
        sweep_d   = sweep_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        cnt_d     = cnt_q;
        err_a_d   = err_a_q;
        err_b_d   = err_b_q;
        err_ra_d  = err_ra_q;
        err_dut_d = err_dut_q;
        err_ref_d = err_ref_q;
`ifdef FP_SWEEP_FLAGS_CMP_EN
        eflags_dut_d = eflags_dut_q;
        eflags_ref_d = eflags_ref_q;
        eexc_dut_d   = eexc_dut_q;
        eexc_ref_d   = eexc_ref_q;
`endif

        case (state_q)
            IDLE, DONE, HALT: begin
                if (start) begin
                    state_d   = RUN;
                    a_d       = '0;
                    b_d       = '0;
                    ra_d      = sweep_ra ? NRAS'(1) : ra_fixed;
                    stop_d    = stop_on_err;
                    sweep_d   = sweep_ra;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    cnt_d     = '0;
                    err_a_d   = '0;
                    err_b_d   = '0;
                    err_ra_d  = '0;
                    err_dut_d = '0;
                    err_ref_d = '0;
`ifdef FP_SWEEP_FLAGS_CMP_EN
                    eflags_dut_d = '0;
                    eflags_ref_d = '0;
                    eexc_dut_d   = '0;
                    eexc_ref_d   = '0;
`endif
                end
            end
            RUN: begin
                if (last_c) begin
                    state_d = DRAIN;
                end else begin
                    b_d = b_nxt_c;
                    if (b_wrap_c) begin
                        a_d = a_nxt_c;
                        if (a_wrap_c && sweep_q) ra_d = ra_q << 1;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_c) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Mismatch bookkeeping overrides the normal sweep progression.
        if (mismatch_c) begin
            error_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
            if (!error_q) begin
                err_a_d   = cmp_c.a;
                err_b_d   = cmp_c.b;
                err_ra_d  = cmp_c.ra;
                err_dut_d = s_dut;
                err_ref_d = s_ref;
`ifdef FP_SWEEP_FLAGS_CMP_EN
                eflags_dut_d = flags_dut;
                eflags_ref_d = flags_ref;
                eexc_dut_d   = exc_dut;
                eexc_ref_d   = exc_ref;
`endif
            end
            if (stop_q) begin
                state_d = HALT;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                a_d     = a_q;
                b_d     = b_q;
                ra_d    = ra_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ra_q      <= '0;
            stop_q    <= 1'b0;
            sweep_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cnt_q     <= '0;
            err_a_q   <= '0;
            err_b_q   <= '0;
            err_ra_q  <= '0;
            err_dut_q <= '0;
            err_ref_q <= '0;
`ifdef FP_SWEEP_FLAGS_CMP_EN
            eflags_dut_q <= '0;
            eflags_ref_q <= '0;
            eexc_dut_q   <= '0;
            eexc_ref_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ra_q      <= ra_d;
            stop_q    <= stop_d;
            sweep_q   <= sweep_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cnt_q     <= cnt_d;
            err_a_q   <= err_a_d;
            err_b_q   <= err_b_d;
            err_ra_q  <= err_ra_d;
            err_dut_q <= err_dut_d;
            err_ref_q <= err_ref_d;
`ifdef FP_SWEEP_FLAGS_CMP_EN
            eflags_dut_q <= eflags_dut_d;
            eflags_ref_q <= eflags_ref_d;
            eexc_dut_q   <= eexc_dut_d;
            eexc_ref_q   <= eexc_ref_d;
`endif
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign ra        = ra_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_count = cnt_q;
    assign err_a     = err_a_q;
    assign err_b     = err_b_q;
    assign err_ra    = err_ra_q;
    assign err_dut   = err_dut_q;
    assign err_ref   = err_ref_q;
`ifdef FP_SWEEP_FLAGS_CMP_EN
    assign err_flags_dut = eflags_dut_q;
    assign err_flags_ref = eflags_ref_q;
    assign err_exc_dut   = eexc_dut_q;
    assign err_exc_ref   = eexc_ref_q;
`endif

endmodule

// File: tb/tb_fp_sweep_cmp.sv
// Directed bench: two small-format sweepers (LAT=0 CW=32, LAT=3 CW=2) with synthetic units.
module tb_fp_sweep_cmp;
    import fp_sweep_cmp_pkg::*;

    localparam int unsigned W   = 6;
    localparam int          NV  = 56;
    localparam int          TOT = NV * NV;
    localparam int          L1  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [W-1:0] vals [NV];

    // Instance 0: combinational units, 32-bit counter
    logic clr0 = 1'b0, start0 = 1'b0, stop0 = 1'b0, sweep0 = 1'b0, fault0 = 1'b0;
    logic [NRAS-1:0] rafix0 = '0;
    logic [W-1:0] a0, b0, sdut0, sref0, err_a0, err_b0, err_dut0, err_ref0;
    logic [NRAS-1:0] ra0, err_ra0;
    logic busy0, done0, error0;
    logic [31:0] err_count0;

    // Instance 1: 3-cycle units, 2-bit counter
    logic clr1 = 1'b0, start1 = 1'b0, stop1 = 1'b0, sweep1 = 1'b0;
    logic [1:0] fault1 = 2'd0;
    logic [NRAS-1:0] rafix1 = '0;
    logic [W-1:0] a1, b1, sdut1, sref1, err_a1, err_b1, err_dut1, err_ref1;
    logic [NRAS-1:0] ra1, err_ra1;
    logic busy1, done1, error1;
    logic [1:0] err_count1;
    logic [W-1:0] pr [L1];
    logic [W-1:0] pd [L1];
    logic hit1;

`ifdef FP_SWEEP_FLAGS_CMP_EN
    logic [NTYPES-1:0] fl_zero = '0;
    logic [NEXCEPTIONS-1:0] ex_zero = '0;
    logic [NTYPES-1:0] efd0, efr0, efd1, efr1;
    logic [NEXCEPTIONS-1:0] eed0, eer0, eed1, eer1;
`endif

    function automatic logic [W-1:0] fref(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [NRAS-1:0] r);
        return W'(x + y) ^ W'(r);
    endfunction

    function automatic int idx_of(input logic [W-1:0] v);
        for (int i = 0; i < NV; i++) if (vals[i] == v) return i;
        return -1;
    endfunction

    assign sref0 = fref(a0, b0, ra0);
    assign sdut0 = sref0 ^ W'(fault0 && a0 == 6'h05 && b0 == 6'h22);

    assign hit1 = (fault1 == 2'd1 && a1 == 6'h0C && b1 == 6'h2C) ||
                  (fault1 == 2'd2 && a1 == 6'h0C && b1 < 6'd5);
    always @(posedge clk) begin
        pr[0] <= fref(a1, b1, ra1);
        pd[0] <= fref(a1, b1, ra1) ^ W'(hit1);
        for (int i = 1; i < L1; i++) begin
            pr[i] <= pr[i-1];
            pd[i] <= pd[i-1];
        end
    end
    assign sref1 = pr[L1-1];
    assign sdut1 = pd[L1-1];

    fp_sweep_cmp #(.NEXP(3), .NSIG(2), .LAT(0), .CW(32)) u0 (
        .clk(clk), .clr(clr0), .start(start0), .stop_on_err(stop0), .sweep_ra(sweep0),
        .ra_fixed(rafix0), .a(a0), .b(b0), .ra(ra0), .s_dut(sdut0), .s_ref(sref0),
        .busy(busy0), .done(done0), .error(error0), .err_count(err_count0),
        .err_a(err_a0), .err_b(err_b0), .err_ra(err_ra0), .err_dut(err_dut0), .err_ref(err_ref0)
`ifdef FP_SWEEP_FLAGS_CMP_EN
        , .flags_dut(fl_zero), .flags_ref(fl_zero), .exc_dut(ex_zero), .exc_ref(ex_zero),
        .err_flags_dut(efd0), .err_flags_ref(efr0), .err_exc_dut(eed0), .err_exc_ref(eer0)
`endif
    );

    fp_sweep_cmp #(.NEXP(3), .NSIG(2), .LAT(L1), .CW(2)) u1 (
        .clk(clk), .clr(clr1), .start(start1), .stop_on_err(stop1), .sweep_ra(sweep1),
        .ra_fixed(rafix1), .a(a1), .b(b1), .ra(ra1), .s_dut(sdut1), .s_ref(sref1),
        .busy(busy1), .done(done1), .error(error1), .err_count(err_count1),
        .err_a(err_a1), .err_b(err_b1), .err_ra(err_ra1), .err_dut(err_dut1), .err_ref(err_ref1)
`ifdef FP_SWEEP_FLAGS_CMP_EN
        , .flags_dut(fl_zero), .flags_ref(fl_zero), .exc_dut(ex_zero), .exc_ref(ex_zero),
        .err_flags_dut(efd1), .err_flags_ref(efr1), .err_exc_dut(eed1), .err_exc_ref(eer1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr0 = 1'b1;
        clr1 = 1'b1;
        tick();
        tick();
        clr0 = 1'b0;
        clr1 = 1'b0;
        checks++; if ({a0, b0, ra0} !== '0) $display("FAIL rst0_ops got %h exp 0", {a0, b0, ra0}); else passed++;
        checks++; if ({busy0, done0, error0} !== 3'b000) $display("FAIL rst0_flags got %b exp 000", {busy0, done0, error0}); else passed++;
        checks++; if ({err_count0, err_a0, err_b0, err_ra0, err_dut0, err_ref0} !== '0) $display("FAIL rst0_err got %h exp 0", {err_count0, err_a0, err_b0, err_ra0, err_dut0, err_ref0}); else passed++;
        checks++; if ({a1, b1, ra1, busy1, done1, error1, err_count1} !== '0) $display("FAIL rst1_state got %h exp 0", {a1, b1, ra1, busy1, done1, error1, err_count1}); else passed++;
        checks++; if ({err_a1, err_b1, err_ra1, err_dut1, err_ref1} !== '0) $display("FAIL rst1_err got %h exp 0", {err_a1, err_b1, err_ra1, err_dut1, err_ref1}); else passed++;
    endtask

    task automatic test_full_sweep();
        int cnt = 0, seq_bad = 0, exp7 = 0, kk;
        logic [NRAS-1:0] r;
        stop0 = 1'b0; sweep0 = 1'b1; fault0 = 1'b0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        while (busy0 && cnt < 20000) begin
            kk = (cnt < TOT * int'(NRAS)) ? cnt : TOT * int'(NRAS) - 1;
            r  = NRAS'(1) << (kk / TOT);
            if (a0 !== vals[(kk / NV) % NV] || b0 !== vals[kk % NV] || ra0 !== r) seq_bad++;
            if (a0[4:2] == 3'b111 || b0[4:2] == 3'b111) exp7++;
            cnt++;
            tick();
        end
        checks++; if (cnt !== TOT * int'(NRAS) + 1) $display("FAIL full_busy_cycles got %0d exp %0d", cnt, TOT * int'(NRAS) + 1); else passed++;
        checks++; if (seq_bad !== 0) $display("FAIL full_sequence got %0d bad cycles exp 0", seq_bad); else passed++;
        checks++; if (exp7 !== 0) $display("FAIL full_no_exp7 got %0d exp 0", exp7); else passed++;
        checks++; if ({done0, error0} !== 2'b10) $display("FAIL full_done_err got %b exp 10", {done0, error0}); else passed++;
        checks++; if (err_count0 !== 32'd0) $display("FAIL full_count got %0d exp 0", err_count0); else passed++;
        checks++; if ({a0, b0, ra0} !== {6'h3B, 6'h3B, 5'b10000}) $display("FAIL full_last got %h exp %h", {a0, b0, ra0}, {6'h3B, 6'h3B, 5'b10000}); else passed++;
    endtask

    task automatic test_fault_halt();
        int cnt = 0, k;
        logic [W-1:0] good;
        k = idx_of(6'h05) * NV + idx_of(6'h22);
        good = fref(6'h05, 6'h22, 5'b00001);
        stop0 = 1'b1; sweep0 = 1'b1; fault0 = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        while (busy0 && cnt < 20000) begin cnt++; tick(); end
        checks++; if (cnt !== k + 1) $display("FAIL halt_busy_cycles got %0d exp %0d", cnt, k + 1); else passed++;
        checks++; if ({done0, error0, err_count0} !== {2'b11, 32'd1}) $display("FAIL halt_status got %h exp %h", {done0, error0, err_count0}, {2'b11, 32'd1}); else passed++;
        checks++; if ({err_a0, err_b0, err_ra0} !== {6'h05, 6'h22, 5'b00001}) $display("FAIL halt_err_ops got %h exp %h", {err_a0, err_b0, err_ra0}, {6'h05, 6'h22, 5'b00001}); else passed++;
        checks++; if ({err_dut0, err_ref0} !== {good ^ 6'h01, good}) $display("FAIL halt_err_res got %h exp %h", {err_dut0, err_ref0}, {good ^ 6'h01, good}); else passed++;
        for (int i = 0; i < 5; i++) tick();
        checks++; if ({a0, b0, busy0} !== {6'h05, 6'h22, 1'b0}) $display("FAIL halt_frozen got %h exp %h", {a0, b0, busy0}, {6'h05, 6'h22, 1'b0}); else passed++;
    endtask

    task automatic test_fault_continue();
        int cnt = 0;
        stop0 = 1'b0; sweep0 = 1'b1; fault0 = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        while (busy0 && cnt < 20000) begin cnt++; tick(); end
        checks++; if (cnt !== TOT * int'(NRAS) + 1) $display("FAIL cont_busy_cycles got %0d exp %0d", cnt, TOT * int'(NRAS) + 1); else passed++;
        checks++; if (err_count0 !== 32'(NRAS)) $display("FAIL cont_count got %0d exp %0d", err_count0, NRAS); else passed++;
        checks++; if ({done0, error0, err_ra0} !== {2'b11, 5'b00001}) $display("FAIL cont_status got %b exp %b", {done0, error0, err_ra0}, {2'b11, 5'b00001}); else passed++;
        fault0 = 1'b0;
    endtask

    task automatic test_clr_restart();
        int cnt = 0;
        stop0 = 1'b0; sweep0 = 1'b0; rafix0 = 5'b00100; fault0 = 1'b0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        clr0 = 1'b1; tick(); clr0 = 1'b0;
        checks++; if ({busy0, done0, a0, b0, err_count0} !== '0) $display("FAIL clr_mid_run got %h exp 0", {busy0, done0, a0, b0, err_count0}); else passed++;
        start0 = 1'b1; tick(); start0 = 1'b0;
        checks++; if ({busy0, a0, b0, ra0, err_count0} !== {1'b1, 6'h00, 6'h00, 5'b00100, 32'd0}) $display("FAIL restart_first got %h exp %h", {busy0, a0, b0, ra0, err_count0}, {1'b1, 6'h00, 6'h00, 5'b00100, 32'd0}); else passed++;
        for (int i = 0; i < 9; i++) tick();
        start0 = 1'b1; tick(); start0 = 1'b0;
        checks++; if ({a0, b0} !== {vals[0], vals[10]}) $display("FAIL start_while_busy got %h exp %h", {a0, b0}, {vals[0], vals[10]}); else passed++;
        while (busy0 && cnt < 20000) begin cnt++; tick(); end
        checks++; if ({done0, error0, ra0} !== {2'b10, 5'b00100}) $display("FAIL fixed_ra_done got %b exp %b", {done0, error0, ra0}, {2'b10, 5'b00100}); else passed++;
    endtask

    task automatic test_lat_halt();
        int cnt = 0, k;
        logic [W-1:0] good;
        k = idx_of(6'h0C) * NV + idx_of(6'h2C);
        good = fref(6'h0C, 6'h2C, 5'b00100);
        stop1 = 1'b1; sweep1 = 1'b0; rafix1 = 5'b00100; fault1 = 2'd1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        while (busy1 && cnt < 20000) begin cnt++; tick(); end
        checks++; if (cnt !== k + L1 + 1) $display("FAIL lat_busy_cycles got %0d exp %0d", cnt, k + L1 + 1); else passed++;
        checks++; if ({done1, error1, err_count1} !== 4'b1101) $display("FAIL lat_status got %b exp 1101", {done1, error1, err_count1}); else passed++;
        checks++; if ({err_a1, err_b1, err_ra1} !== {6'h0C, 6'h2C, 5'b00100}) $display("FAIL lat_err_ops got %h exp %h", {err_a1, err_b1, err_ra1}, {6'h0C, 6'h2C, 5'b00100}); else passed++;
        checks++; if ({err_dut1, err_ref1} !== {good ^ 6'h01, good}) $display("FAIL lat_err_res got %h exp %h", {err_dut1, err_ref1}, {good ^ 6'h01, good}); else passed++;
        for (int i = 0; i < 4; i++) tick();
        checks++; if ({a1, b1} !== {6'h0C, vals[(k + L1) % NV]}) $display("FAIL lat_frozen got %h exp %h", {a1, b1}, {6'h0C, vals[(k + L1) % NV]}); else passed++;
    endtask

    task automatic test_saturation();
        int cnt = 0;
        stop1 = 1'b0; sweep1 = 1'b0; rafix1 = 5'b00010; fault1 = 2'd2;
        start1 = 1'b1; tick(); start1 = 1'b0;
        checks++; if ({error1, err_count1} !== 3'b000) $display("FAIL sat_cleared got %b exp 000", {error1, err_count1}); else passed++;
        while (busy1 && cnt < 20000) begin cnt++; tick(); end
        checks++; if (cnt !== TOT + L1 + 1) $display("FAIL sat_busy_cycles got %0d exp %0d", cnt, TOT + L1 + 1); else passed++;
        checks++; if ({done1, error1, err_count1} !== 4'b1111) $display("FAIL sat_status got %b exp 1111", {done1, error1, err_count1}); else passed++;
        checks++; if ({err_a1, err_b1, err_ra1} !== {6'h0C, 6'h00, 5'b00010}) $display("FAIL sat_first got %h exp %h", {err_a1, err_b1, err_ra1}, {6'h0C, 6'h00, 5'b00010}); else passed++;
    endtask

    initial begin
        int n = 0;
        for (int v = 0; v < 64; v++) begin
            logic [W-1:0] x;
            x = W'(v);
            if (x[4:2] != 3'b111) begin
                vals[n] = x;
                n++;
            end
        end
        test_reset();
        test_full_sweep();
        test_fault_halt();
        test_fault_continue();
        test_clr_restart();
        test_lat_halt();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
